// File: rtl/prio_steer_pipe.sv
// Two-stage valid/ready pipeline that steers one of two data words and
// arbitrates a request vector (fixed priority or round-robin) into grant/index.
module prio_steer_pipe #(
    parameter int N      = 8,
    parameter int INVERT = 1,
    parameter int IDXW   = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_req,
    input  logic [N-1:0]    in_a,
    input  logic [N-1:0]    in_b,
    input  logic            in_sel,
    input  logic            in_mode,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_mux,
    output logic [N-1:0]    out_gnt,
    output logic [IDXW-1:0] out_idx,
    output logic            out_none
);

    logic            s1_v_r;
    logic [N-1:0]    s1_req_r;
    logic [N-1:0]    s1_a_r;
    logic [N-1:0]    s1_b_r;
    logic            s1_sel_r;
    logic            s1_mode_r;

    logic            s2_v_r;
    logic [N-1:0]    mux_r;
    logic [N-1:0]    gnt_r;
    logic [IDXW-1:0] idx_r;
    logic            none_r;

    logic [IDXW-1:0] ptr_r;

    logic            s2_adv_s;
    logic            accept_s;
    logic            xfer_s;
    logic [N-1:0]    sel_word_s;
    logic [N-1:0]    mux_s;
    logic [N-1:0]    gnt_s;
    logic [IDXW-1:0] idx_s;
    logic [IDXW-1:0] ptr_nxt_s;
    logic            found_s;
    logic [IDXW:0]   pos_s;

    assign s2_adv_s = ~s2_v_r | out_ready;
    assign in_ready = ~s1_v_r | s2_adv_s;
    assign accept_s = in_valid & in_ready;
    assign xfer_s   = s1_v_r & s2_adv_s;

    // Steering of the selected data word with optional polarity inversion
    always_comb begin
        sel_word_s = '0;
        mux_s      = '0;
        if (s1_sel_r) begin
            sel_word_s = s1_b_r;
        end else begin
            sel_word_s = s1_a_r;
        end
        if (INVERT != 0) begin
            mux_s = ~sel_word_s;
        end else begin
            mux_s = sel_word_s;
        end
    end

    // Arbitration: scan from 0 (fixed) or from ptr with modulo-N wrap (round-robin)
    always_comb begin
        gnt_s     = '0;
        idx_s     = '0;
        found_s   = 1'b0;
        pos_s     = '0;
        ptr_nxt_s = ptr_r;
        for (int k = 0; k < N; k++) begin
            if (s1_mode_r) begin
                pos_s = {1'b0, ptr_r} + (IDXW+1)'(k);
                if (pos_s >= (IDXW+1)'(N)) begin
                    pos_s = pos_s - (IDXW+1)'(N);
                end else begin
                    pos_s = pos_s;
                end
            end else begin
                pos_s = (IDXW+1)'(k);
            end
            if (!found_s && s1_req_r[pos_s[IDXW-1:0]]) begin
                found_s = 1'b1;
                idx_s   = pos_s[IDXW-1:0];
            end else begin
                found_s = found_s;
            end
        end
        if (found_s) begin
            gnt_s[idx_s] = 1'b1;
        end else begin
            gnt_s = '0;
        end
        if (idx_s == IDXW'(N-1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = idx_s + IDXW'(1);
        end
    end

    // Stage 1: capture an accepted transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_r    <= 1'b0;
            s1_req_r  <= '0;
            s1_a_r    <= '0;
            s1_b_r    <= '0;
            s1_sel_r  <= 1'b0;
            s1_mode_r <= 1'b0;
        end else if (accept_s) begin
            s1_v_r    <= 1'b1;
            s1_req_r  <= in_req;
            s1_a_r    <= in_a;
            s1_b_r    <= in_b;
            s1_sel_r  <= in_sel;
            s1_mode_r <= in_mode;
        end else if (s2_adv_s) begin
            s1_v_r    <= 1'b0;
        end
    end

    // Stage 2: registered results that drive the outputs directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_r <= 1'b0;
            mux_r  <= '0;
            gnt_r  <= '0;
            idx_r  <= '0;
            none_r <= 1'b0;
        end else if (xfer_s) begin
            s2_v_r <= 1'b1;
            mux_r  <= mux_s;
            gnt_r  <= gnt_s;
            idx_r  <= idx_s;
            none_r <= ~found_s;
        end else if (s2_adv_s) begin
            s2_v_r <= 1'b0;
        end
    end

    // Round-robin pointer; only RR transfers with a live request move it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (xfer_s && s1_mode_r && found_s) begin
            ptr_r <= ptr_nxt_s;
        end
    end

    assign out_valid = s2_v_r;
    assign out_mux   = mux_r;
    assign out_gnt   = gnt_r;
    assign out_idx   = idx_r;
    assign out_none  = none_r;

endmodule

// File: tb/tb_prio_steer_pipe.sv
// Directed bench for prio_steer_pipe: N=8 inverted, N=8 true polarity, N=5.
module tb_prio_steer_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    logic       in_valid, in_sel, in_mode, out_ready;
    logic [7:0] in_req, in_a, in_b;

    logic       inv_ready, inv_valid, inv_none;
    logic [7:0] inv_mux, inv_gnt;
    logic [2:0] inv_idx;
    logic       pos_ready, pos_valid, pos_none;
    logic [7:0] pos_mux, pos_gnt;
    logic [2:0] pos_idx;

    logic       in_valid5, in_sel5, in_mode5, out_ready5, in_ready5, out_valid5, out_none5;
    logic [4:0] in_req5, in_a5, in_b5, out_mux5, out_gnt5;
    logic [2:0] out_idx5;

    prio_steer_pipe #(.N(8), .INVERT(1)) u_inv (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inv_ready),
        .in_req(in_req), .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_mode(in_mode),
        .out_valid(inv_valid), .out_ready(out_ready), .out_mux(inv_mux),
        .out_gnt(inv_gnt), .out_idx(inv_idx), .out_none(inv_none));

    prio_steer_pipe #(.N(8), .INVERT(0)) u_pos (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(pos_ready),
        .in_req(in_req), .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_mode(in_mode),
        .out_valid(pos_valid), .out_ready(out_ready), .out_mux(pos_mux),
        .out_gnt(pos_gnt), .out_idx(pos_idx), .out_none(pos_none));

    prio_steer_pipe #(.N(5), .INVERT(1)) u_n5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5),
        .in_req(in_req5), .in_a(in_a5), .in_b(in_b5), .in_sel(in_sel5), .in_mode(in_mode5),
        .out_valid(out_valid5), .out_ready(out_ready5), .out_mux(out_mux5),
        .out_gnt(out_gnt5), .out_idx(out_idx5), .out_none(out_none5));

    task automatic idle();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send8(input logic [7:0] req, input logic [7:0] a, input logic [7:0] b,
                         input logic sel, input logic mode);
        in_req = req; in_a = a; in_b = b; in_sel = sel; in_mode = mode;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send5(input logic [4:0] req);
        in_req5 = req; in_mode5 = 1'b1; in_valid5 = 1'b1; out_ready5 = 1'b1;
        @(posedge clk); #1;
        in_valid5 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        vecs++; if (inv_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b exp 0", inv_valid); end
        vecs++; if ({inv_mux, inv_gnt, inv_idx, inv_none} !== 20'h0) begin errs++;
            $display("FAIL reset_outs got mux=%h gnt=%h idx=%0d none=%b exp all 0", inv_mux, inv_gnt, inv_idx, inv_none); end
        vecs++; if ({out_valid5, out_mux5, out_gnt5, out_idx5} !== 14'h0) begin errs++;
            $display("FAIL reset_n5 got v=%b mux=%h gnt=%h idx=%0d exp all 0", out_valid5, out_mux5, out_gnt5, out_idx5); end
        #3 rst_n = 1'b1;
        #1;
        vecs++; if ({inv_ready, pos_ready, in_ready5} !== 3'b111) begin errs++;
            $display("FAIL reset_ready got %b exp 111", {inv_ready, pos_ready, in_ready5}); end
        @(posedge clk); #1;
    endtask

    task automatic test_fixed();
        send8(8'h2C, 8'h00, 8'h00, 1'b0, 1'b0);
        vecs++; if (inv_valid !== 1'b1) begin errs++; $display("FAIL fixed_valid got %b exp 1", inv_valid); end
        vecs++; if (inv_gnt !== 8'h04) begin errs++; $display("FAIL fixed_gnt got %h exp 04", inv_gnt); end
        vecs++; if (inv_idx !== 3'd2) begin errs++; $display("FAIL fixed_idx got %0d exp 2", inv_idx); end
        vecs++; if (inv_none !== 1'b0) begin errs++; $display("FAIL fixed_none got %b exp 0", inv_none); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_idx [4] = '{3'd0, 3'd7, 3'd0, 3'd7};
        idle();
        in_req = 8'h81; in_mode = 1'b1; in_sel = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) in_valid = 1'b0;
            @(posedge clk); #1;
            vecs++; if (inv_valid !== 1'b1 || inv_idx !== exp_idx[i]) begin errs++;
                $display("FAIL rr_seq%0d got v=%b idx=%0d exp v=1 idx=%0d", i, inv_valid, inv_idx, exp_idx[i]); end
        end
        send8(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        vecs++; if (inv_none !== 1'b1 || inv_gnt !== 8'h00 || inv_idx !== 3'd0) begin errs++;
            $display("FAIL rr_zero got none=%b gnt=%h idx=%0d exp 1 00 0", inv_none, inv_gnt, inv_idx); end
        send8(8'h81, 8'h00, 8'h00, 1'b0, 1'b1);
        vecs++; if (inv_idx !== 3'd0 || inv_gnt !== 8'h01) begin errs++;
            $display("FAIL rr_after_zero got idx=%0d gnt=%h exp 0 01", inv_idx, inv_gnt); end
        send8(8'h81, 8'h00, 8'h00, 1'b0, 1'b0);
        vecs++; if (inv_idx !== 3'd0) begin errs++; $display("FAIL mixed_fixed got idx=%0d exp 0", inv_idx); end
        send8(8'h81, 8'h00, 8'h00, 1'b0, 1'b1);
        vecs++; if (inv_idx !== 3'd7 || inv_gnt !== 8'h80) begin errs++;
            $display("FAIL mixed_rr got idx=%0d gnt=%h exp 7 80", inv_idx, inv_gnt); end
    endtask

    task automatic test_steering();
        send8(8'h10, 8'h0F, 8'hF0, 1'b0, 1'b0);
        vecs++; if (inv_mux !== 8'hF0) begin errs++; $display("FAIL steer_inv_a got %h exp F0", inv_mux); end
        vecs++; if (pos_mux !== 8'h0F) begin errs++; $display("FAIL steer_pos_a got %h exp 0F", pos_mux); end
        vecs++; if (pos_idx !== 3'd4) begin errs++; $display("FAIL steer_idx got %0d exp 4", pos_idx); end
        send8(8'h10, 8'h0F, 8'hF0, 1'b1, 1'b0);
        vecs++; if (inv_mux !== 8'h0F) begin errs++; $display("FAIL steer_inv_b got %h exp 0F", inv_mux); end
        vecs++; if (pos_mux !== 8'hF0) begin errs++; $display("FAIL steer_pos_b got %h exp F0", pos_mux); end
    endtask

    task automatic test_back_pressure();
        int sent = 0;
        int rx = 0;
        logic acc, take, stalled_prev;
        logic [7:0] snap_mux, snap_gnt;
        logic [2:0] snap_idx;
        stalled_prev = 1'b0; snap_mux = 8'h00; snap_gnt = 8'h00; snap_idx = 3'd0;
        idle();
        in_req = 8'h06; in_mode = 1'b0; in_sel = 1'b0; in_b = 8'h00;
        in_a = 8'd1; in_valid = 1'b1;
        for (int c = 0; c < 40 && rx < 6; c++) begin
            out_ready = (c >= 4);
            #1;
            if (c == 2) begin
                vecs++; if (pos_ready !== 1'b0 || sent != 2) begin errs++;
                    $display("FAIL bp_ready_drop got ready=%b sent=%0d exp 0 2", pos_ready, sent); end
            end
            if (stalled_prev) begin
                vecs++; if (pos_valid !== 1'b1 || pos_mux !== snap_mux || pos_gnt !== snap_gnt || pos_idx !== snap_idx) begin errs++;
                    $display("FAIL bp_hold got v=%b mux=%h gnt=%h idx=%0d exp 1 %h %h %0d",
                             pos_valid, pos_mux, pos_gnt, pos_idx, snap_mux, snap_gnt, snap_idx); end
            end
            acc  = in_valid && pos_ready;
            take = pos_valid && out_ready;
            if (take) begin
                rx++;
                vecs++; if (pos_mux !== 8'(rx) || pos_idx !== 3'd1) begin errs++;
                    $display("FAIL bp_order got mux=%0d idx=%0d exp %0d 1", pos_mux, pos_idx, rx); end
            end
            stalled_prev = pos_valid && !out_ready;
            snap_mux = pos_mux; snap_gnt = pos_gnt; snap_idx = pos_idx;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                if (sent == 6) in_valid = 1'b0;
                else in_a = 8'(sent + 1);
            end
        end
        vecs++; if (rx != 6 || sent != 6) begin errs++;
            $display("FAIL bp_count got rx=%0d sent=%0d exp 6 6", rx, sent); end
        vecs++; if (pos_valid !== 1'b0) begin errs++; $display("FAIL bp_no_dup got valid=%b exp 0", pos_valid); end
    endtask

    task automatic test_wrap_n5();
        logic [2:0] exp_idx [3] = '{3'd0, 3'd4, 3'd0};
        logic [4:0] exp_gnt [3] = '{5'b00001, 5'b10000, 5'b00001};
        for (int i = 0; i < 3; i++) begin
            send5(5'b10001);
            vecs++; if (out_valid5 !== 1'b1 || out_idx5 !== exp_idx[i] || out_gnt5 !== exp_gnt[i]) begin errs++;
                $display("FAIL n5_wrap%0d got v=%b idx=%0d gnt=%b exp 1 %0d %b",
                         i, out_valid5, out_idx5, out_gnt5, exp_idx[i], exp_gnt[i]); end
        end
    endtask

    task automatic test_reset_mid();
        idle();
        in_req = 8'hFF; in_mode = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        vecs++; if (inv_valid !== 1'b1 || inv_ready !== 1'b0) begin errs++;
            $display("FAIL mid_full got v=%b ready=%b exp 1 0", inv_valid, inv_ready); end
        #2 rst_n = 1'b0;
        #1;
        vecs++; if (inv_valid !== 1'b0 || pos_valid !== 1'b0) begin errs++;
            $display("FAIL mid_async got inv=%b pos=%b exp 0 0", inv_valid, pos_valid); end
        #1 rst_n = 1'b1;
        #1;
        vecs++; if (inv_ready !== 1'b1) begin errs++; $display("FAIL mid_ready got %b exp 1", inv_ready); end
        @(posedge clk); #1;
        vecs++; if (inv_valid !== 1'b0) begin errs++; $display("FAIL mid_flushed got valid=%b exp 0", inv_valid); end
        send8(8'hFF, 8'h00, 8'h00, 1'b0, 1'b1);
        vecs++; if (inv_idx !== 3'd0 || inv_gnt !== 8'h01) begin errs++;
            $display("FAIL mid_ptr got idx=%0d gnt=%h exp 0 01", inv_idx, inv_gnt); end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_sel = 1'b0; in_mode = 1'b0; out_ready = 1'b1;
        in_req = 8'h00; in_a = 8'h00; in_b = 8'h00;
        in_valid5 = 1'b0; in_sel5 = 1'b0; in_mode5 = 1'b1; out_ready5 = 1'b1;
        in_req5 = 5'h00; in_a5 = 5'h00; in_b5 = 5'h00;
        #8;
        test_reset();
        test_fixed();
        test_round_robin();
        test_steering();
        test_back_pressure();
        test_wrap_n5();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
